// File: rtl/uart_bridge_pkg.sv
// Purpose: shared types and constants for the uart FIFO bridge.
// Contents: byte width, byte type, TX and RX handshake state encodings.
// Used by: uart_fifo_bridge_if, byte_fifo, uart_fifo_bridge.
`timescale 1ns/1ps
package uart_bridge_pkg;

  localparam int UART_BYTE_W = 8;

  typedef logic [UART_BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_BUSY,
    TX_RELEASE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_WAIT,
    RX_SETTLE,
    RX_ACK
  } rx_state_t;

endpackage

// File: rtl/uart_fifo_bridge_if.sv
// Purpose: level handshake between the bridge and the unchanged uart core.
// Ports: start_tx/tx_value/tx_done for transmit, rx_available/rx_value/rx_clear for receive.
// Modports: master = bridge side, slave = uart core side.
`timescale 1ns/1ps
interface uart_fifo_bridge_if;
  import uart_bridge_pkg::*;

  logic  start_tx;
  byte_t tx_value;
  logic  tx_done;
  logic  rx_available;
  byte_t rx_value;
  logic  rx_clear;

  modport master (
    output start_tx, tx_value, rx_clear,
    input  tx_done, rx_available, rx_value
  );

  modport slave (
    input  start_tx, tx_value, rx_clear,
    output tx_done, rx_available, rx_value
  );

endinterface

// File: rtl/uart_fifo_bridge_byte_fifo.sv
// Purpose: synchronous first-word fall-through byte FIFO (module byte_fifo).
// Ports: clk, rst (sync, active-high), push/push_dat, pop, full, empty, head (0 when empty).
// Pointers carry one extra wrap bit; simultaneous push and pop on a full FIFO are both honoured.
`timescale 1ns/1ps
module byte_fifo
  import uart_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  byte_t push_dat,
  input  logic  pop,
  output logic  full,
  output logic  empty,
  output byte_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  byte_t       mem_q [DEPTH];
  byte_t       mem_d [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same slot index, opposite lap: writer is exactly one lap ahead.
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push = push && (!full || do_pop);

  assign head = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_dat;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: empty pointers mask stale contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_fifo_bridge.sv
// Purpose: CPU-side TX/RX byte FIFOs in front of the uart core's level handshakes.
// Ports: clk, rst (sync, active-high); CPU wr_en/wr_data, rd_en/rd_data, clr_flags, status flags;
//        core handshake through uart_fifo_bridge_if.master; irq_mask/irq only with UART_BRIDGE_IRQ_EN.
// A TX byte stays in its FIFO slot until the core reports tx_done, so the in-flight byte counts toward tx_full.
`timescale 1ns/1ps
module uart_fifo_bridge
  import uart_bridge_pkg::*;
#(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wr_en,
  input  byte_t wr_data,
  input  logic  rd_en,
  output byte_t rd_data,
  input  logic  clr_flags,
  output logic  tx_full,
  output logic  tx_empty,
  output logic  rx_empty,
  output logic  tx_ovf,
  output logic  rx_ovf,
  uart_fifo_bridge_if.master core
`ifdef UART_BRIDGE_IRQ_EN
  ,
  input  logic [1:0] irq_mask,
  output logic       irq
`endif
);

  tx_state_t tx_state_q, tx_state_d;
  rx_state_t rx_state_q, rx_state_d;
  logic      start_tx_q, start_tx_d;
  byte_t     tx_value_q, tx_value_d;
  logic      rx_clear_q, rx_clear_d;
  logic      tx_ovf_q, tx_ovf_d;
  logic      rx_ovf_q, rx_ovf_d;

  logic      txf_push, txf_pop, txf_full, txf_empty;
  byte_t     txf_head;
  logic      rxf_push, rxf_full, rxf_empty;
  byte_t     rxf_head;
  logic      rd_pop_ok;

  // A full TX FIFO drops the write even if the head pops this cycle.
  assign txf_push  = wr_en && !txf_full;
  assign rd_pop_ok = rd_en && !rxf_empty;

  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (txf_push),
    .push_dat (wr_data),
    .pop      (txf_pop),
    .full     (txf_full),
    .empty    (txf_empty),
    .head     (txf_head)
  );

  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (rxf_push),
    .push_dat (core.rx_value),
    .pop      (rd_en),
    .full     (rxf_full),
    .empty    (rxf_empty),
    .head     (rxf_head)
  );

  // TX handshake: present head, hold until tx_done, then wait for tx_done to drop.
  always_comb begin
    tx_state_d = tx_state_q;
    start_tx_d = start_tx_q;
    tx_value_d = tx_value_q;
    txf_pop    = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        // tx_done check keeps start_tx from ever rising against a stale done.
        if (!txf_empty && !core.tx_done) begin
          start_tx_d = 1'b1;
          tx_value_d = txf_head;
          tx_state_d = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (core.tx_done) begin
          txf_pop    = 1'b1;
          start_tx_d = 1'b0;
          tx_state_d = TX_RELEASE;
        end
      end
      TX_RELEASE: begin
        if (!core.tx_done) begin
          tx_state_d = TX_IDLE;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        start_tx_d = 1'b0;
      end
    endcase
  end

  // RX handshake: skip the first rx_available cycle, whose rx_value is not yet valid.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_clear_d = rx_clear_q;
    rxf_push   = 1'b0;
    case (rx_state_q)
      RX_WAIT: begin
        if (core.rx_available) begin
          rx_state_d = RX_SETTLE;
        end
      end
      RX_SETTLE: begin
        // While full the byte stays parked in the core; a CPU pop unblocks it at once.
        if (!rxf_full || rd_pop_ok) begin
          rxf_push   = 1'b1;
          rx_clear_d = 1'b1;
          rx_state_d = RX_ACK;
        end
      end
      RX_ACK: begin
        if (!core.rx_available) begin
          rx_clear_d = 1'b0;
          rx_state_d = RX_WAIT;
        end
      end
      default: begin
        rx_state_d = RX_WAIT;
        rx_clear_d = 1'b0;
      end
    endcase
  end

  // Sticky error flags; a clear beats a same-cycle set.
  always_comb begin
    tx_ovf_d = tx_ovf_q | (wr_en & txf_full);
    rx_ovf_d = rx_ovf_q | (rd_en & rxf_empty);
    if (clr_flags) begin
      tx_ovf_d = 1'b0;
      rx_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_WAIT;
      start_tx_q <= 1'b0;
      tx_value_q <= '0;
      rx_clear_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_ovf_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      start_tx_q <= start_tx_d;
      tx_value_q <= tx_value_d;
      rx_clear_q <= rx_clear_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovf_q   <= rx_ovf_d;
    end
  end

  assign core.start_tx = start_tx_q;
  assign core.tx_value = tx_value_q;
  assign core.rx_clear = rx_clear_q;

  assign rd_data  = rxf_head;
  assign tx_full  = txf_full;
  assign tx_empty = txf_empty && (tx_state_q == TX_IDLE);
  assign rx_empty = rxf_empty;
  assign tx_ovf   = tx_ovf_q;
  assign rx_ovf   = rx_ovf_q;

`ifdef UART_BRIDGE_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = (~rxf_empty & irq_mask[0]) | (tx_empty & irq_mask[1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge with a behavioural uart core on the handshake interface.
// The core answers start_tx with tx_done after 20 cycles (unless stalled) and logs each byte sent.
// Expected data comes from queues of bytes written/delivered by the bench.
`timescale 1ns/1ps
module tb_uart_fifo_bridge;
  import uart_bridge_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  wr_en = 1'b0;
  byte_t wr_data = '0;
  logic  rd_en = 1'b0;
  byte_t rd_data;
  logic  clr_flags = 1'b0;
  logic  tx_full, tx_empty, rx_empty, tx_ovf, rx_ovf;
`ifdef UART_BRIDGE_IRQ_EN
  logic [1:0] irq_mask = 2'b00;
  logic       irq;
`endif

  uart_fifo_bridge_if bif ();

  uart_fifo_bridge #(.TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .clr_flags (clr_flags),
    .tx_full   (tx_full),
    .tx_empty  (tx_empty),
    .rx_empty  (rx_empty),
    .tx_ovf    (tx_ovf),
    .rx_ovf    (rx_ovf),
    .core      (bif.master)
`ifdef UART_BRIDGE_IRQ_EN
    ,
    .irq_mask  (irq_mask),
    .irq       (irq)
`endif
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  logic  stall = 1'b0;
  int    tx_cnt = 0;
  byte_t tx_seen [$];

  // Behavioural uart core, transmit side.
  initial begin
    bif.tx_done      = 1'b0;
    bif.rx_available = 1'b0;
    bif.rx_value     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_cnt      = 0;
        bif.tx_done = 1'b0;
      end else if (bif.tx_done) begin
        if (!bif.start_tx) bif.tx_done = 1'b0;
      end else if (bif.start_tx && !stall) begin
        tx_cnt++;
        if (tx_cnt == 20) begin
          tx_cnt      = 0;
          bif.tx_done = 1'b1;
          tx_seen.push_back(bif.tx_value);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_byte(input byte_t b);
    wr_en   = 1'b1;
    wr_data = b;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic read_pulse();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  // Core-side delivery of one received byte: first cycle carries junk, then the real value.
  task automatic rx_deliver(input byte_t b);
    bif.rx_available = 1'b1;
    bif.rx_value     = 8'h00;
    step();
    bif.rx_value = b;
    for (int i = 0; i < 20 && !bif.rx_clear; i++) step();
    total++;
    if (bif.rx_clear !== 1'b1) begin
      bad++;
      $display("FAIL rx_deliver_clear got=%b exp=1", bif.rx_clear);
    end
    bif.rx_available = 1'b0;
    for (int i = 0; i < 20 && bif.rx_clear; i++) step();
    total++;
    if (bif.rx_clear !== 1'b0) begin
      bad++;
      $display("FAIL rx_deliver_release got=%b exp=0", bif.rx_clear);
    end
    bif.rx_value = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (bif.start_tx !== 1'b0) begin bad++; $display("FAIL reset_start_tx got=%b exp=0", bif.start_tx); end
    total++; if (bif.tx_value !== 8'h00) begin bad++; $display("FAIL reset_tx_value got=%h exp=00", bif.tx_value); end
    total++; if (bif.rx_clear !== 1'b0) begin bad++; $display("FAIL reset_rx_clear got=%b exp=0", bif.rx_clear); end
    total++; if (tx_empty !== 1'b1) begin bad++; $display("FAIL reset_tx_empty got=%b exp=1", tx_empty); end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL reset_rx_empty got=%b exp=1", rx_empty); end
    total++; if (tx_ovf !== 1'b0 || rx_ovf !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", tx_ovf, rx_ovf); end
    total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_tx_pair();
    int base;
    base    = tx_seen.size();
    wr_en   = 1'b1;
    wr_data = 8'h55;
    step();
    wr_data = 8'hA3;
    total++; if (bif.start_tx !== 1'b0) begin bad++; $display("FAIL tx_latency_early got=%b exp=0", bif.start_tx); end
    step();
    wr_en = 1'b0;
    total++; if (bif.start_tx !== 1'b1) begin bad++; $display("FAIL tx_latency_start got=%b exp=1", bif.start_tx); end
    total++; if (bif.tx_value !== 8'h55) begin bad++; $display("FAIL tx_first_value got=%h exp=55", bif.tx_value); end
    for (int i = 0; i < 40 && !bif.tx_done; i++) step();
    total++; if (bif.tx_done !== 1'b1) begin bad++; $display("FAIL tx_done_timeout got=%b exp=1", bif.tx_done); end
    step();
    total++; if (bif.start_tx !== 1'b0) begin bad++; $display("FAIL tx_start_fall got=%b exp=0", bif.start_tx); end
    for (int i = 0; i < 10 && !bif.start_tx; i++) begin
      total++;
      if (bif.tx_done === 1'b1 && bif.start_tx === 1'b1) begin bad++; $display("FAIL tx_start_during_done got=1 exp=0"); end
      step();
    end
    total++; if (bif.start_tx !== 1'b1 || bif.tx_value !== 8'hA3) begin
      bad++; $display("FAIL tx_second_value got=%b/%h exp=1/a3", bif.start_tx, bif.tx_value);
    end
    for (int i = 0; i < 100 && !tx_empty; i++) step();
    total++; if (tx_seen.size() != base + 2) begin bad++; $display("FAIL tx_pair_count got=%0d exp=%0d", tx_seen.size() - base, 2); end
    else if (tx_seen[base] !== 8'h55 || tx_seen[base+1] !== 8'hA3) begin
      bad++; $display("FAIL tx_pair_order got=%h,%h exp=55,a3", tx_seen[base], tx_seen[base+1]);
    end
  endtask

  task automatic test_tx_overflow();
    byte_t b [5];
    int    base;
    base  = tx_seen.size();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = b[i];
      if (i == 4) begin
        total++; if (tx_full !== 1'b1 || tx_ovf !== 1'b0) begin
          bad++; $display("FAIL tx_full_before_drop got=%b/%b exp=1/0", tx_full, tx_ovf);
        end
      end
      step();
    end
    wr_en = 1'b0;
    total++; if (tx_full !== 1'b1) begin bad++; $display("FAIL tx_full got=%b exp=1", tx_full); end
    total++; if (tx_ovf !== 1'b1) begin bad++; $display("FAIL tx_ovf_set got=%b exp=1", tx_ovf); end
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    total++; if (tx_ovf !== 1'b0) begin bad++; $display("FAIL tx_ovf_clear got=%b exp=0", tx_ovf); end
    stall = 1'b0;
    for (int i = 0; i < 400 && !tx_empty; i++) step();
    total++; if (tx_seen.size() != base + 4) begin bad++; $display("FAIL tx_ovf_count got=%0d exp=4", tx_seen.size() - base); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (tx_seen[base+i] !== b[i]) begin bad++; $display("FAIL tx_ovf_order[%0d] got=%h exp=%h", i, tx_seen[base+i], b[i]); end
      end
    end
  endtask

  task automatic test_rx_capture();
    bif.rx_available = 1'b1;
    bif.rx_value     = 8'h00;
    step();
    bif.rx_value = 8'h7E;
    step();
    total++; if (bif.rx_clear !== 1'b1) begin bad++; $display("FAIL rx_clear_rise got=%b exp=1", bif.rx_clear); end
    total++; if (rd_data !== 8'h7E || rx_empty !== 1'b0) begin bad++; $display("FAIL rx_capture got=%h/%b exp=7e/0", rd_data, rx_empty); end
    step();
    total++; if (bif.rx_clear !== 1'b1) begin bad++; $display("FAIL rx_clear_hold got=%b exp=1", bif.rx_clear); end
    bif.rx_available = 1'b0;
    step();
    total++; if (bif.rx_clear !== 1'b0) begin bad++; $display("FAIL rx_clear_fall got=%b exp=0", bif.rx_clear); end
    read_pulse();
    total++; if (rx_empty !== 1'b1 || rd_data !== 8'h00) begin bad++; $display("FAIL rx_pop_empty got=%b/%h exp=1/00", rx_empty, rd_data); end
    total++; if (rx_ovf !== 1'b0) begin bad++; $display("FAIL rx_ovf_spurious got=%b exp=0", rx_ovf); end
    read_pulse();
    total++; if (rx_ovf !== 1'b1) begin bad++; $display("FAIL rx_ovf_set got=%b exp=1", rx_ovf); end
    rd_en     = 1'b1;
    clr_flags = 1'b1;
    step();
    rd_en     = 1'b0;
    clr_flags = 1'b0;
    total++; if (rx_ovf !== 1'b0) begin bad++; $display("FAIL rx_ovf_clr_priority got=%b exp=0", rx_ovf); end
  endtask

  task automatic test_rx_backpressure();
    byte_t exp_q [$];
    for (int i = 1; i <= 4; i++) begin
      rx_deliver(8'(i));
      exp_q.push_back(8'(i));
    end
    bif.rx_available = 1'b1;
    bif.rx_value     = 8'h00;
    step();
    bif.rx_value = 8'h05;
    for (int i = 0; i < 6; i++) step();
    total++; if (bif.rx_clear !== 1'b0) begin bad++; $display("FAIL rx_bp_clear got=%b exp=0", bif.rx_clear); end
    total++; if (rd_data !== 8'h01) begin bad++; $display("FAIL rx_bp_head got=%h exp=01", rd_data); end
    read_pulse();
    void'(exp_q.pop_front());
    exp_q.push_back(8'h05);
    total++; if (bif.rx_clear !== 1'b1) begin bad++; $display("FAIL rx_bp_release got=%b exp=1", bif.rx_clear); end
    bif.rx_available = 1'b0;
    for (int i = 0; i < 10 && bif.rx_clear; i++) step();
    bif.rx_value = '0;
    while (exp_q.size() > 0) begin
      total++;
      if (rd_data !== exp_q[0]) begin bad++; $display("FAIL rx_bp_data got=%h exp=%h", rd_data, exp_q[0]); end
      void'(exp_q.pop_front());
      read_pulse();
    end
    total++; if (rx_empty !== 1'b1) begin bad++; $display("FAIL rx_bp_drained got=%b exp=1", rx_empty); end
  endtask

  task automatic test_random();
    byte_t tx_exp [$];
    byte_t rx_q [$];
    byte_t b;
    int    base;
    int    op;
    base = tx_seen.size();
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 3));
      if (op == 0 && (tx_exp.size() - (tx_seen.size() - base)) < 3) begin
        b = 8'($urandom);
        write_byte(b);
        tx_exp.push_back(b);
      end else if (op == 1 && rx_q.size() < 4) begin
        b = 8'($urandom);
        rx_deliver(b);
        rx_q.push_back(b);
      end else if (op == 2 && rx_q.size() > 0) begin
        total++;
        if (rd_data !== rx_q[0]) begin bad++; $display("FAIL rand_rx_data got=%h exp=%h", rd_data, rx_q[0]); end
        void'(rx_q.pop_front());
        read_pulse();
      end else begin
        step();
      end
    end
    while (rx_q.size() > 0) begin
      total++;
      if (rd_data !== rx_q[0]) begin bad++; $display("FAIL rand_rx_drain got=%h exp=%h", rd_data, rx_q[0]); end
      void'(rx_q.pop_front());
      read_pulse();
    end
    for (int i = 0; i < 2000 && !(tx_empty && tx_seen.size() - base == tx_exp.size()); i++) step();
    total++;
    if (tx_seen.size() - base != tx_exp.size()) begin
      bad++; $display("FAIL rand_tx_count got=%0d exp=%0d", tx_seen.size() - base, tx_exp.size());
    end else begin
      for (int i = 0; i < tx_exp.size(); i++) begin
        total++;
        if (tx_seen[base+i] !== tx_exp[i]) begin bad++; $display("FAIL rand_tx_data[%0d] got=%h exp=%h", i, tx_seen[base+i], tx_exp[i]); end
      end
    end
    total++; if (tx_ovf !== 1'b0 || rx_ovf !== 1'b0) begin bad++; $display("FAIL rand_flags got=%b%b exp=00", tx_ovf, rx_ovf); end
  endtask

  task automatic test_reset_mid_tx();
    int base;
`ifdef UART_BRIDGE_IRQ_EN
    irq_mask = 2'b10;
`endif
    stall = 1'b1;
    write_byte(8'($urandom));
    for (int i = 0; i < 10 && !bif.start_tx; i++) step();
    total++; if (bif.start_tx !== 1'b1) begin bad++; $display("FAIL mid_tx_busy got=%b exp=1", bif.start_tx); end
    base = tx_seen.size();
    rst  = 1'b1;
    step();
    total++; if (bif.start_tx !== 1'b0) begin bad++; $display("FAIL mid_tx_start got=%b exp=0", bif.start_tx); end
    total++; if (tx_empty !== 1'b1) begin bad++; $display("FAIL mid_tx_empty got=%b exp=1", tx_empty); end
    rst   = 1'b0;
    stall = 1'b0;
    step();
    step();
`ifdef UART_BRIDGE_IRQ_EN
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL mid_tx_irq got=%b exp=1", irq); end
`endif
    for (int i = 0; i < 30; i++) step();
    total++; if (tx_seen.size() != base || bif.start_tx !== 1'b0) begin
      bad++; $display("FAIL mid_tx_dropped got=%0d/%b exp=0/0", tx_seen.size() - base, bif.start_tx);
    end
  endtask

  initial begin
    test_reset();
    test_tx_pair();
    test_tx_overflow();
    test_rx_capture();
    test_rx_backpressure();
    test_random();
    test_reset_mid_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
